key_debounce_multi: RTL and testbench
=====================================

Name: key_debounce_multi

Overview:
Parametrised multi-channel key debouncer and the next generation of the team's single-key debouncer. Each channel synchronises an asynchronous key input, debounces it with a cycle-exact stability window, and emits a debounced level, a polarity-normalised pressed flag, and one-cycle press, release and long-press event pulses. The block sits between board push-buttons or switches and control FSMs, such as menu/UI logic and mode selects, that need clean edges instead of raw levels.

Parameters:
NUM_KEYS, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 1_300_000, consecutive stable synced samples required to accept a new level; 20 ms at 65 MHz (>=1)
LONG_CYCLES, 65_000_000, cycles a key must stay pressed before long_press fires; 0 disables long-press detection
ACTIVE_LOW, 1, 1: pressed level is 0 and idle level is 1; 0: the reverse

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ikey  input  NUM_KEYS  raw asynchronous key inputs
okey  output  NUM_KEYS  debounced raw-polarity level
pressed  output  NUM_KEYS  debounced level normalised so 1 = pressed
press  output  NUM_KEYS  one-cycle pulse when a key becomes pressed
release  output  NUM_KEYS  one-cycle pulse when a key becomes released
long_press  output  NUM_KEYS  one-cycle pulse after LONG_CYCLES of continuous press

Behaviour:
- Reset is asynchronous and active-low on rst_n, clocked on clk. Everything in the block uses the rising edge of clk.
- IDLE = ACTIVE_LOW ? 1 : 0.
- During reset:
  - all synchroniser stages = IDLE; okey = {NUM_KEYS{IDLE}}
  - pressed = 0; press, release and long_press = 0
  - all counters = 0
- Channels are fully independent. Simultaneous events on any set of channels are handled in the same cycle.
- Synchroniser: a SYNC_STAGES-deep flop chain per channel. Its output is s.
- Debounce counter cnt, width $clog2(DEBOUNCE_CYCLES+1):
  - if s == okey: cnt <= 0 (any glitch back to the current level restarts the window)
  - else if cnt == DEBOUNCE_CYCLES-1: okey <= s and cnt <= 0
  - else: cnt <= cnt + 1
- Latency: with ikey held at a new level, okey changes on edge SYNC_STAGES+DEBOUNCE_CYCLES, counting the first edge that samples the new level as edge 1.
- Glitch rejection: a pulse shorter than DEBOUNCE_CYCLES synced cycles never reaches okey.
- pressed = okey XOR ACTIVE_LOW, and is registered together with okey.
- Event pulses:
  - press = 1 for exactly one cycle, the cycle in which pressed first reads 1 (registered on the same edge as the okey update)
  - release behaves the same way on the transition to 0
  - press and release are never both high on one channel in the same cycle
- Long press (LONG_CYCLES > 0):
  - hold counter hcnt, width $clog2(LONG_CYCLES+1), is cleared on the edge pressed goes 1
  - hcnt increments each cycle while pressed = 1
  - when hcnt == LONG_CYCLES-1, long_press pulses for one cycle and hcnt saturates
  - exactly one long_press per press, i.e. no auto-repeat
  - on release, hcnt <= 0; a release before the threshold produces no long_press
- LONG_CYCLES == 0: long_press is tied to 0 and the hold logic is not generated.
- Reset asserted mid-count, mid-press or mid-pulse:
  - all state returns to reset values immediately (asynchronously)
  - no press/release pulse is generated for the reset-induced level change
  - after deassertion, a key that is physically held is recognised as a normal press after the full latency
- Elaboration errors: SYNC_STAGES < 2, DEBOUNCE_CYCLES < 1 or NUM_KEYS < 1.

Test Plan:
Bench parameters for all scenarios: NUM_KEYS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, LONG_CYCLES=32, ACTIVE_LOW=1.
1. Reset, then idle with ikey=2'b11 -> okey=2'b11, pressed=0, press/release/long_press stay 0 for 100 cycles.
2. Clean press: ikey[0] 1->0 and held -> okey[0]=0 and pressed[0]=1 after edge 10; press[0] high for exactly one cycle; channel 1 unchanged.
3. Bounce then glitch: ikey[0] toggles every 3 cycles for 40 cycles, then stays 0 -> okey[0] falls exactly 10 edges after the last transition, with a single press pulse. Separately, a 7-cycle low glitch gives no okey change and no pulse.
4. Long press: hold ch0 pressed -> long_press[0] single pulse 32 cycles after the press pulse; holding 100 more cycles gives no further pulse. Release -> release[0] pulse after 10 edges. A second press released after 20 cycles gives no long_press.
5. Simultaneous: both channels pressed on the same cycle -> identical okey, press and long_press timing on both. Staggering ch1 by 3 cycles shifts only ch1's events by 3.
6. Reset mid-operation: assert rst_n=0 at cnt=5, and again during a held press at hcnt=20 -> outputs return to idle at once with no pulses. After release of rst_n with ikey[0] still held low, press[0] fires 10 edges later and long_press[0] fires 32 cycles after that.

Source files
------------

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: per-channel synchroniser, cycle-exact stability window,
// debounced level plus press / release / long-press one-cycle event pulses.
module key_debounce_multi #(
  parameter int NUM_KEYS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_300_000,
  parameter int LONG_CYCLES     = 65_000_000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] ikey,
  output logic [NUM_KEYS-1:0] okey,
  output logic [NUM_KEYS-1:0] pressed,
  output logic [NUM_KEYS-1:0] press,
  // "release" is a reserved SystemVerilog keyword, hence the prefix
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] long_press
);

  localparam logic           IDLE    = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || NUM_KEYS < 1) begin : g_param_err
    $error("key_debounce_multi: illegal parameters (SYNC_STAGES>=2, DEBOUNCE_CYCLES>=1, NUM_KEYS>=1)");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          cnt_r;
    logic                   okey_r;
    logic                   pressed_r;
    logic                   press_r;
    logic                   release_r;
    logic                   s_s;
    logic                   upd_s;

    assign s_s            = sync_r[SYNC_STAGES-1];
    assign okey[i]        = okey_r;
    assign pressed[i]     = pressed_r;
    assign press[i]       = press_r;
    assign key_release[i] = release_r;

    // Accept the new level on the last cycle of an unbroken stability window
    always_comb begin
      upd_s = 1'b0;
      if ((s_s != okey_r) && (cnt_r == DB_LAST)) begin
        upd_s = 1'b1;
      end else begin
        upd_s = 1'b0;
      end
    end

    // Synchroniser, debounce window and level/edge registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_r    <= {SYNC_STAGES{IDLE}};
        cnt_r     <= CNT_ZERO;
        okey_r    <= IDLE;
        pressed_r <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        sync_r    <= {sync_r[SYNC_STAGES-2:0], ikey[i]};
        press_r   <= 1'b0;
        release_r <= 1'b0;
        if (s_s == okey_r) begin
          cnt_r <= CNT_ZERO;
        end else if (upd_s) begin
          cnt_r     <= CNT_ZERO;
          okey_r    <= s_s;
          pressed_r <= s_s ^ IDLE;
          press_r   <= s_s ^ IDLE;
          release_r <= ~(s_s ^ IDLE);
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end
    end

    if (LONG_CYCLES > 0) begin : g_long
      localparam int            HW     = $clog2(LONG_CYCLES + 1);
      localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
      localparam logic [HW-1:0] H_SAT  = HW'(LONG_CYCLES);
      localparam logic [HW-1:0] H_ONE  = HW'(1);
      localparam logic [HW-1:0] H_ZERO = HW'(0);

      logic [HW-1:0] hcnt_r;
      logic          long_r;

      assign long_press[i] = long_r;

      // Hold counter saturates past the threshold so each press yields one pulse
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hcnt_r <= H_ZERO;
          long_r <= 1'b0;
        end else begin
          long_r <= 1'b0;
          if (upd_s) begin
            hcnt_r <= H_ZERO;
          end else if (pressed_r) begin
            if (hcnt_r == H_LAST) begin
              long_r <= 1'b1;
              hcnt_r <= H_SAT;
            end else if (hcnt_r != H_SAT) begin
              hcnt_r <= hcnt_r + H_ONE;
            end else begin
              hcnt_r <= hcnt_r;
            end
          end else begin
            hcnt_r <= H_ZERO;
          end
        end
      end
    end else begin : g_no_long
      assign long_press[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: stimulus queues expected event pulses with
// their cycle, a monitor matches every pulse the DUT emits against that queue.
module tb_key_debounce_multi;

  localparam int KIND_PRESS = 0;
  localparam int KIND_REL   = 1;
  localparam int KIND_LONG  = 2;

  typedef struct {
    int         kind;
    logic [1:0] mask;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] ikey;
  logic [1:0] okey;
  logic [1:0] pressed;
  logic [1:0] press;
  logic [1:0] key_release;
  logic [1:0] long_press;

  exp_t q[$];
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   t;

  key_debounce_multi #(
    .NUM_KEYS       (2),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(8),
    .LONG_CYCLES    (32),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ikey       (ikey),
    .okey       (okey),
    .pressed    (pressed),
    .press      (press),
    .key_release(key_release),
    .long_press (long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int kd);
    if (kd == KIND_PRESS) return "press";
    else if (kd == KIND_REL) return "release";
    else return "long_press";
  endfunction

  task automatic push(input int kd, input logic [1:0] m, input int c);
    exp_t e;
    e.kind = kd;
    e.mask = m;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic match_kind(input int kd, input logic [1:0] v);
    int found;
    if (v != 2'b00) begin
      found = -1;
      for (int k = 0; k < q.size(); k++) begin
        if (found < 0 && q[k].kind == kd && q[k].cyc == cyc) found = k;
      end
      n_checks++;
      if (found < 0) begin
        n_fail++;
        $display("FAIL unexpected_%s: got mask %b expected none at cycle %0d", kname(kd), v, cyc);
      end else begin
        if (v !== q[found].mask) begin
          n_fail++;
          $display("FAIL %s_mask: got %b expected %b at cycle %0d", kname(kd), v, q[found].mask, cyc);
        end
        q.delete(found);
      end
    end
  endtask

  // Monitor: retire overdue expectations, then match any pulse seen this cycle
  always @(negedge clk) begin
    for (int k = q.size() - 1; k >= 0; k--) begin
      if (q[k].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_%s: got nothing expected mask %b at cycle %0d", kname(q[k].kind), q[k].mask, q[k].cyc);
        q.delete(k);
      end
    end
    match_kind(KIND_PRESS, press);
    match_kind(KIND_REL, key_release);
    match_kind(KIND_LONG, long_press);
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_okey"}, {6'b0, okey}, 8'b0000_0011);
    chk({name, "_pressed"}, {6'b0, pressed}, 8'b0000_0000);
    chk({name, "_pulses"}, {2'b0, press, key_release, long_press}, 8'b0000_0000);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    ikey     = 2'b11;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk_idle("idle100");

    // Clean press, long press, long hold, release
    t = cyc;
    ikey[0] = 1'b0;
    push(KIND_PRESS, 2'b01, t + 10);
    push(KIND_LONG, 2'b01, t + 42);
    wait_until(t + 9);
    chk("clean_pre_okey", {6'b0, okey}, 8'b0000_0011);
    wait_until(t + 10);
    chk("clean_okey", {6'b0, okey}, 8'b0000_0010);
    chk("clean_pressed", {6'b0, pressed}, 8'b0000_0001);
    wait_until(t + 11);
    chk("clean_press_width", {6'b0, press}, 8'b0000_0000);
    chk("clean_pressed_hold", {6'b0, pressed}, 8'b0000_0001);
    wait_until(t + 150);
    t = cyc;
    ikey[0] = 1'b1;
    push(KIND_REL, 2'b01, t + 10);
    wait_until(t + 9);
    chk("rel_pre_pressed", {6'b0, pressed}, 8'b0000_0001);
    wait_until(t + 10);
    chk("rel_okey", {6'b0, okey}, 8'b0000_0011);
    wait_until(t + 30);

    // Short press: released before the long-press threshold
    t = cyc;
    ikey[0] = 1'b0;
    push(KIND_PRESS, 2'b01, t + 10);
    wait_until(t + 30);
    ikey[0] = 1'b1;
    push(KIND_REL, 2'b01, t + 40);
    wait_until(t + 90);
    chk_idle("short_press");

    // Bounce every 3 cycles, then settle low
    for (int k = 0; k < 14; k++) begin
      ikey[0] = (k % 2 == 0) ? 1'b0 : 1'b1;
      repeat (3) @(negedge clk);
    end
    t = cyc;
    ikey[0] = 1'b0;
    push(KIND_PRESS, 2'b01, t + 10);
    wait_until(t + 9);
    chk("bounce_pre_okey", {6'b0, okey}, 8'b0000_0011);
    wait_until(t + 10);
    chk("bounce_okey", {6'b0, okey}, 8'b0000_0010);
    ikey[0] = 1'b1;
    push(KIND_REL, 2'b01, t + 20);
    wait_until(t + 40);

    // 7-cycle glitch is rejected
    t = cyc;
    ikey[0] = 1'b0;
    wait_until(t + 7);
    ikey[0] = 1'b1;
    wait_until(t + 25);
    chk_idle("glitch7");

    // Both channels together
    t = cyc;
    ikey = 2'b00;
    push(KIND_PRESS, 2'b11, t + 10);
    push(KIND_LONG, 2'b11, t + 42);
    wait_until(t + 10);
    chk("simul_okey", {6'b0, okey}, 8'b0000_0000);
    chk("simul_pressed", {6'b0, pressed}, 8'b0000_0011);
    wait_until(t + 60);
    ikey = 2'b11;
    push(KIND_REL, 2'b11, t + 70);
    wait_until(t + 90);

    // Channel 1 staggered by 3 cycles
    t = cyc;
    ikey[0] = 1'b0;
    push(KIND_PRESS, 2'b01, t + 10);
    push(KIND_LONG, 2'b01, t + 42);
    wait_until(t + 3);
    ikey[1] = 1'b0;
    push(KIND_PRESS, 2'b10, t + 13);
    push(KIND_LONG, 2'b10, t + 45);
    wait_until(t + 11);
    chk("stagger_okey", {6'b0, okey}, 8'b0000_0010);
    wait_until(t + 60);
    ikey = 2'b11;
    push(KIND_REL, 2'b11, t + 70);
    wait_until(t + 90);

    // Reset in the middle of a debounce window
    t = cyc;
    ikey[0] = 1'b0;
    wait_until(t + 7);
    rst_n = 1'b0;
    #1;
    chk_idle("rst_midcount");
    ikey = 2'b11;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk_idle("rst_midcount_after");

    // Reset during a held press, key kept held through reset
    t = cyc;
    ikey[0] = 1'b0;
    push(KIND_PRESS, 2'b01, t + 10);
    wait_until(t + 30);
    chk("held_pressed", {6'b0, pressed}, 8'b0000_0001);
    rst_n = 1'b0;
    #1;
    chk_idle("rst_midpress");
    repeat (3) @(negedge clk);
    t = cyc;
    rst_n = 1'b1;
    push(KIND_PRESS, 2'b01, t + 10);
    push(KIND_LONG, 2'b01, t + 42);
    wait_until(t + 9);
    chk("rst_recover_pre", {6'b0, pressed}, 8'b0000_0000);
    wait_until(t + 10);
    chk("rst_recover_pressed", {6'b0, pressed}, 8'b0000_0001);
    wait_until(t + 60);
    t = cyc;
    ikey = 2'b11;
    push(KIND_REL, 2'b01, t + 10);
    wait_until(t + 30);
    chk_idle("final");

    for (int k = 0; k < q.size(); k++) begin
      n_checks++;
      n_fail++;
      $display("FAIL leftover_%s: got nothing expected mask %b at cycle %0d", kname(q[k].kind), q[k].mask, q[k].cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
